flit_pkt_tx: RTL

- Packetizer/transmitter at a NoC local-input port.
- Accepts one packet descriptor (destination, total flit count, head payload), then a stream of payload words.
- Emits the corresponding HEAD / BODY / TAIL flit sequence over a valid/ready flit interface into a router VC buffer.
- Output flit is registered; at most one packet is in flight per instance, i.e. one instance per VC.

---
 rtl/ravenoc_pkg.sv | 41 ++++
 rtl/flit_out_reg.sv | 44 ++++
 rtl/flit_pkt_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
// Shared NoC types and widths for the flit transmitter.
// Flit layout: type_f in the top bits, payload below.
package ravenoc_pkg;

  localparam int X_WIDTH         = 2;
  localparam int Y_WIDTH         = 2;
  localparam int PKT_WIDTH       = 9;
  localparam int FLIT_WIDTH      = 34;
  localparam int FLIT_TP_WIDTH   = 2;
  localparam int FLIT_DATA_WIDTH = FLIT_WIDTH - FLIT_TP_WIDTH;
  localparam int MIN_DATA_WIDTH  = FLIT_DATA_WIDTH - X_WIDTH
                                 - Y_WIDTH - PKT_WIDTH;
  localparam int VC_WIDTH        = 1;

  localparam logic [PKT_WIDTH-1:0] MIN_SIZE_FLIT = PKT_WIDTH'(1);

  typedef enum logic [FLIT_TP_WIDTH-1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef struct packed {
    flit_type_t                type_f;
    logic [X_WIDTH-1:0]        x_dest;
    logic [Y_WIDTH-1:0]        y_dest;
    logic [PKT_WIDTH-1:0]      pkt_size;
    logic [MIN_DATA_WIDTH-1:0] data;
  } s_flit_head_data_t;

  typedef struct packed {
    flit_type_t                 type_f;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } s_flit_data_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } tx_st_t;

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry registered flit output slot.
// Holds the flit while stalled; a load replaces it.
module flit_out_reg
  import ravenoc_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  load_i,
  input  logic [FLIT_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [FLIT_WIDTH-1:0] data_o,
  output logic                  slot_free_o
);

  logic                  valid_q, valid_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;

  // next slot contents: load wins, else drain on handshake
  always_comb begin
    valid_d = valid_q & ~ready_i;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // slot registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign slot_free_o = ~valid_q | ready_i;

endmodule

// File: rtl/flit_pkt_tx.sv
// Packetizer: descriptor + payload words in,
// HEAD/BODY/TAIL flits out to one router VC.
module flit_pkt_tx
  import ravenoc_pkg::*;
#(
  parameter int VC_ID         = 0,
  parameter int MAX_PKT_FLITS = 256
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       pkt_valid_i,
  output logic                       pkt_ready_o,
  input  logic [X_WIDTH-1:0]         pkt_x_dest_i,
  input  logic [Y_WIDTH-1:0]         pkt_y_dest_i,
  input  logic [PKT_WIDTH-1:0]       pkt_size_i,
  input  logic [MIN_DATA_WIDTH-1:0]  pkt_hdata_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [FLIT_DATA_WIDTH-1:0] data_i,
  output logic [FLIT_WIDTH-1:0]      fdata_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [VC_WIDTH-1:0]        vc_id_o,
  output logic                       busy_o,
  output logic                       err_o
);

  tx_st_t               state_q, state_d;
  logic [PKT_WIDTH-1:0] rem_q, rem_d;
  logic                 err_q, err_d;

  logic                  slot_free;
  logic                  load;
  logic                  pkt_hs;
  logic                  data_hs;
  logic                  illegal;
  flit_type_t            ld_type;
  logic [FLIT_WIDTH-1:0] flit_d;
  s_flit_head_data_t     head;
  s_flit_data_t          body;

  assign vc_id_o = VC_WIDTH'(VC_ID);
  assign err_o   = err_q;

  // state, flit counter and error pulse registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // next state: leave IDLE on a multi-flit head, return on tail
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pkt_hs && rem_d != '0) state_d = ST_BODY;
      ST_BODY: if (data_hs && rem_q == PKT_WIDTH'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // handshakes, flit assembly and counter update
  always_comb begin
    pkt_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    busy_o       = 1'b0;
    pkt_hs       = 1'b0;
    data_hs      = 1'b0;
    load         = 1'b0;
    illegal      = 1'b0;
    ld_type      = HEAD_FLIT;
    rem_d        = rem_q;
    err_d        = 1'b0;
    head         = '0;
    body         = '0;
    flit_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        pkt_ready_o   = slot_free;
        pkt_hs        = pkt_valid_i & slot_free;
        illegal       = (pkt_size_i == '0) ||
                        (pkt_size_i > PKT_WIDTH'(MAX_PKT_FLITS));
        head.type_f   = HEAD_FLIT;
        head.x_dest   = pkt_x_dest_i;
        head.y_dest   = pkt_y_dest_i;
        head.pkt_size = illegal ? MIN_SIZE_FLIT : pkt_size_i;
        head.data     = pkt_hdata_i;
        flit_d        = head;
        if (pkt_hs) begin
          load  = 1'b1;
          err_d = illegal;
          rem_d = illegal ? '0 : pkt_size_i - PKT_WIDTH'(1);
        end
      end
      ST_BODY: begin
        busy_o       = 1'b1;
        data_ready_o = slot_free;
        data_hs      = data_valid_i & slot_free;
        ld_type      = (rem_q > PKT_WIDTH'(1)) ? BODY_FLIT : TAIL_FLIT;
        body.type_f  = ld_type;
        body.data    = data_i;
        flit_d       = body;
        if (data_hs) begin
          load  = 1'b1;
          rem_d = rem_q - PKT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  flit_out_reg u_out (
    .clk         (clk),
    .arst_n      (arst_n),
    .load_i      (load),
    .data_i      (flit_d),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .data_o      (fdata_o),
    .slot_free_o (slot_free)
  );

`ifndef NO_ASSERTIONS
  a_hold: assert property (@(posedge clk) disable iff (!arst_n)
    (valid_o && !ready_i) |=> $stable(fdata_o));
  a_tail: assert property (@(posedge clk) disable iff (!arst_n)
    (load && ld_type == TAIL_FLIT) |-> (state_q == ST_BODY));
`endif

endmodule
